// File: rtl/sigma_delta_cic_decimator.sv
// CIC decimator for the sigma-delta receive path: offset-binary code in, signed
// full-precision samples out at 1/OSR of the enabled rate over valid/ready.
module sigma_delta_cic_decimator #(
  parameter int IN_WIDTH = 1,   // 1..8
  parameter int OSR      = 32,  // power of two, 2..256
  parameter int ORDER    = 3    // 1..4
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                en,
  input  logic [IN_WIDTH-1:0]                 in,
  output logic [IN_WIDTH+ORDER*$clog2(OSR):0] outData,
  output logic                                outValid,
  input  logic                                outReady,
  output logic                                overrun,
  input  logic                                clrOverrun
);
  localparam int CW        = $clog2(OSR);
  localparam int OUT_WIDTH = IN_WIDTH + 1 + ORDER*CW;
  localparam logic [CW-1:0]     CNT_LAST = CW'(OSR - 1);
  localparam logic [IN_WIDTH:0] CODE_MID = (IN_WIDTH+1)'((1 << IN_WIDTH) - 1);

  logic [IN_WIDTH:0]    v_s;
  logic [OUT_WIDTH-1:0] v_ext;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 strobe;
  logic [OUT_WIDTH-1:0] comb_out;

  // 2*in - (2^W - 1): symmetric signed level, never wraps in W+1 bits
  assign v_s    = {in, 1'b0} - CODE_MID;
  assign v_ext  = {{(ORDER*CW){v_s[IN_WIDTH]}}, v_s};
  assign cnt_d  = cnt_q + CW'(1);
  assign strobe = en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rstN)   cnt_q <= '0;
    else if (en) cnt_q <= cnt_d;
  end

  // Integrators wrap modulo 2^OUT_WIDTH; the comb differences undo the wrap.
  for (genvar g = 0; g < ORDER; g++) begin : g_stage
    logic [OUT_WIDTH-1:0] integ_q, integ_d, dly_q, c_in, c_out;
    if (g == 0) begin : g_head
      assign integ_d = integ_q + v_ext;
      assign c_in    = g_stage[ORDER-1].integ_q;
    end else begin : g_tail
      assign integ_d = integ_q + g_stage[g-1].integ_q;
      assign c_in    = g_stage[g-1].c_out;
    end
    assign c_out = c_in - dly_q;

    always_ff @(posedge clk) begin
      if (!rstN) begin
        integ_q <= '0;
        dly_q   <= '0;
      end else begin
        if (en)     integ_q <= integ_d;
        if (strobe) dly_q   <= c_in;
      end
    end
  end

  assign comb_out = g_stage[ORDER-1].c_out;

  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 vld_q, vld_d, ovr_q, ovr_d;

  // Clear is applied first so a coincident overrun event wins.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (clrOverrun) ovr_d = 1'b0;
    if (strobe) begin
      data_d = comb_out;
      vld_d  = 1'b1;
      if (vld_q && !outReady) ovr_d = 1'b1;
    end else if (vld_q && outReady) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign outData  = data_q;
  assign outValid = vld_q;
  assign overrun  = ovr_q;
endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Directed bench: default decimator (1b, OSR 32, N=3) and an 8b/OSR16/N=2 instance.
module tb_sigma_delta_cic_decimator;
  logic        clk = 1'b0;
  logic        rstN, en, rdy_a, clr_a;
  logic        rdy_b, clr_b;
  logic [0:0]  in_a;
  logic [7:0]  in_b;
  logic [16:0] out_a, out_b;
  logic        val_a, val_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  sigma_delta_cic_decimator dut_a (
    .clk(clk), .rstN(rstN), .en(en), .in(in_a), .outData(out_a), .outValid(val_a),
    .outReady(rdy_a), .overrun(ovr_a), .clrOverrun(clr_a));

  sigma_delta_cic_decimator #(.IN_WIDTH(8), .OSR(16), .ORDER(2)) dut_b (
    .clk(clk), .rstN(rstN), .en(en), .in(in_b), .outData(out_b), .outValid(val_b),
    .outReady(rdy_b), .overrun(ovr_b), .clrOverrun(clr_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon = 1'b0, mon_b = 1'b0;
  int q_val[$];
  int q_cyc[$];
  always @(negedge clk) begin
    if (mon && !mon_b && val_a && rdy_a) begin
      q_val.push_back(int'($signed(out_a)));
      q_cyc.push_back(cyc);
    end
    if (mon && mon_b && val_b && rdy_b) begin
      q_val.push_back(int'($signed(out_b)));
      q_cyc.push_back(cyc);
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string name;
    bit    use_b;
    bit    do_rst;
    bit    alt;
    int    val;
    int    en_div;
    int    frames;
    int    chk_from;
    int    exp;
  } phase_t;

  phase_t tbl[6];
  phase_t ph;
  int osr, ncyc, st, prev, cur, frz, sp, drive, k;
  bit vld;

  initial begin
    tbl[0] = '{"a_const1", 1'b0, 1'b1, 1'b0, 1,   1, 6, 3, 32768};
    tbl[1] = '{"a_alt",    1'b0, 1'b1, 1'b1, 0,   1, 6, 3, 0};
    tbl[2] = '{"a_zero",   1'b0, 1'b0, 1'b0, 0,   1, 5, 3, -32768};
    tbl[3] = '{"b_255",    1'b1, 1'b1, 1'b0, 255, 1, 6, 2, 65280};
    tbl[4] = '{"b_0",      1'b1, 1'b0, 1'b0, 0,   1, 6, 2, -65280};
    tbl[5] = '{"a_en4",    1'b0, 1'b1, 1'b0, 1,   4, 5, 3, 32768};

    rstN = 1'b0; en = 1'b0; in_a = '0; in_b = '0;
    rdy_a = 1'b1; clr_a = 1'b0; rdy_b = 1'b1; clr_b = 1'b0;
    step(2);
    chk("reset_data_a", int'(out_a), 0);
    chk("reset_valid_a", int'(val_a), 0);
    chk("reset_ovr_a", int'(ovr_a), 0);
    chk("reset_data_b", int'(out_b), 0);
    rstN = 1'b1;

    for (int p = 0; p < 6; p++) begin
      ph   = tbl[p];
      osr  = ph.use_b ? 16 : 32;
      ncyc = ph.frames * osr * ph.en_div;
      if (ph.do_rst) begin
        rstN = 1'b0; en = 1'b0;
        step(1);
        rstN = 1'b1;
      end
      q_val.delete(); q_cyc.delete();
      mon_b = ph.use_b; mon = 1'b1;
      st   = cyc;
      prev = ph.use_b ? int'($signed(out_b)) : int'($signed(out_a));
      frz  = 0;
      for (int c = 0; c < ncyc; c++) begin
        en    = (c % ph.en_div) == 0;
        drive = ph.alt ? (c % 2) : ph.val;
        in_a  = drive[0:0];
        in_b  = drive[7:0];
        step(1);
        cur = ph.use_b ? int'($signed(out_b)) : int'($signed(out_a));
        vld = ph.use_b ? val_b : val_a;
        if (cur != prev && !vld) frz++;
        prev = cur;
      end
      en = 1'b0;
      @(negedge clk);
      #1;
      mon = 1'b0;

      chk({ph.name, "_count"}, q_val.size(), ph.frames);
      if (q_cyc.size() > 0)
        chk({ph.name, "_first_lat"}, q_cyc[0] - st, (osr - 1) * ph.en_div + 1);
      sp = 0;
      for (int i = 1; i < q_cyc.size(); i++)
        if (q_cyc[i] - q_cyc[i-1] != osr * ph.en_div) sp++;
      chk({ph.name, "_spacing_errs"}, sp, 0);
      for (int j = ph.chk_from; j < ph.frames; j++)
        chk($sformatf("%s_out%0d", ph.name, j), (j < q_val.size()) ? q_val[j] : -999999, ph.exp);
      chk({ph.name, "_overrun"}, int'(ph.use_b ? ovr_b : ovr_a), 0);
      chk({ph.name, "_hold_errs"}, frz, 0);
    end

    // Handshake on the default instance with in=1 constant.
    rstN = 1'b0; en = 1'b0; rdy_a = 1'b0; clr_a = 1'b0;
    step(1);
    rstN = 1'b1; en = 1'b1; in_a = 1'b1;
    step(32);
    chk("hs_s0_valid", int'(val_a), 1);
    chk("hs_s0_data", int'($signed(out_a)), 4495);
    chk("hs_s0_ovr", int'(ovr_a), 0);
    step(32);
    chk("hs_s1_valid", int'(val_a), 1);
    chk("hs_s1_data", int'($signed(out_a)), 26226);
    chk("hs_s1_ovr", int'(ovr_a), 1);
    rdy_a = 1'b1;
    step(1);
    rdy_a = 1'b0;
    chk("hs_consume_valid", int'(val_a), 0);
    chk("hs_consume_data", int'($signed(out_a)), 26226);
    chk("hs_consume_ovr", int'(ovr_a), 1);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("hs_clr_ovr", int'(ovr_a), 0);
    step(30);
    chk("hs_s2_valid", int'(val_a), 1);
    chk("hs_s2_data", int'($signed(out_a)), 32767);
    chk("hs_s2_ovr", int'(ovr_a), 0);
    step(31);
    rdy_a = 1'b1;
    step(1);
    rdy_a = 1'b0;
    chk("hs_coinc_valid", int'(val_a), 1);
    chk("hs_coinc_data", int'($signed(out_a)), 32768);
    chk("hs_coinc_ovr", int'(ovr_a), 0);
    step(31);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("hs_clr_vs_set_ovr", int'(ovr_a), 1);

    // Mid-frame reset with an unconsumed sample and overrun pending.
    step(5);
    rstN = 1'b0;
    step(1);
    chk("midrst_data", int'(out_a), 0);
    chk("midrst_valid", int'(val_a), 0);
    chk("midrst_ovr", int'(ovr_a), 0);
    rstN = 1'b1; rdy_a = 1'b1;
    k = 0;
    while (!val_a && k < 100) begin
      step(1);
      k++;
    end
    chk("midrst_first_lat", k, 32);
    chk("midrst_first_data", int'($signed(out_a)), 4495);

    en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
